// File: rtl/seg_pipe_adder.sv
// Segmented pipelined adder/subtractor: WIDTH bits split into WIDTH/SEG CLA
// segments, one per stage, with a valid/ready stream handshake and result flags.
module seg_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_width_check
    $error("seg_pipe_adder: WIDTH must be a multiple of SEG");
  end

  // Each carry is a flat sum of generate/propagate products, so no carry
  // depends on another carry of the same segment.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           run;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      run    = p[i];
      c[i+1] = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & ci);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en & ~rst;

  // Stage k owns sum bits [HI-1:0] and forwards only the operand bits above HI.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_res;
    logic [HI-1:0]     s_d;
    logic [HI-1:0]     s_q;
    logic              c_q;
    logic              v_q;

    if (k == 0) begin : g_src
      assign a_in = A;
      assign b_in = sub ? ~B : B;
      assign c_in = cin;
      assign v_in = in_valid;
      assign s_d  = seg_res[SEG-1:0];
    end else begin : g_chain
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {seg_res[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_res = cla_seg(a_in[LO +: SEG], b_in[LO +: SEG], c_in);

    // NOTE: data registers are reset along with the valid bits so that S and
    // the flags read 0 during and straight after reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_d;
        c_q <= seg_res[SEG];
        v_q <= v_in;
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end else begin : g_flags
      logic ovf_q;
      logic zero_q;
      // Equal operand signs with a differing result sign is exactly carry-in
      // to the MSB differing from carry-out of the MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= (a_in[WIDTH-1] ~^ b_in[WIDTH-1]) & (s_d[WIDTH-1] ^ a_in[WIDTH-1]);
          zero_q <= ~|s_d;
        end
      end
    end
  end

  assign S         = g_stage[NSEG-1].s_q;
  assign out_valid = g_stage[NSEG-1].v_q;
  assign cout      = g_stage[NSEG-1].c_q;
  assign ovf       = g_stage[NSEG-1].g_flags.ovf_q;
  assign zero      = g_stage[NSEG-1].g_flags.zero_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder: default 64/16 instance plus 32/8 and
// 16/16 instances for latency and arithmetic at other geometries.
module tb_seg_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default geometry
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [63:0] A, B, S;

  seg_pipe_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // WIDTH=32, SEG=8
  logic        iv32, ir32, ov32, or32, co32, of32, z32;
  logic [31:0] a32, b32, s32;

  seg_pipe_adder #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .cin(1'b0), .sub(1'b0),
    .out_valid(ov32), .out_ready(or32),
    .S(s32), .cout(co32), .ovf(of32), .zero(z32)
  );

  // WIDTH=16, SEG=16
  logic        iv16, ir16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, s16;

  seg_pipe_adder #(.WIDTH(16), .SEG(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .A(a16), .B(b16), .cin(1'b0), .sub(1'b0),
    .out_valid(ov16), .out_ready(or16),
    .S(s16), .cout(co16), .ovf(of16), .zero(z16)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to an idle pipeline and count edges until out_valid.
  task automatic run_one(input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic s, output int lat);
    A = a; B = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_32(input logic [31:0] a, input logic [31:0] b, output int lat);
    a32 = a; b32 = b; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_16(input logic [15:0] a, input logic [15:0] b, output int lat);
    a16 = a; b16 = b; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [63:0] q[$];
    int          src;
    int          got;
    int          steps;
    logic        in_fire;
    logic [63:0] held_s;
    logic [2:0]  held_f;
    logic        stale;

    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_S", S, 64'd0);
    check("rst_flags", 64'({cout, ovf, zero}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Carry ripples through every segment
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    check("wrap_latency", 64'(lat), 64'd4);
    check("wrap_valid", 64'(out_valid), 64'd1);
    check("wrap_S", S, 64'd0);
    check("wrap_cout", 64'(cout), 64'd1);
    check("wrap_zero", 64'(zero), 64'd1);
    check("wrap_ovf", 64'(ovf), 64'd0);

    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
    check("povf_S", S, 64'h8000_0000_0000_0000);
    check("povf_ovf", 64'(ovf), 64'd1);
    check("povf_cout", 64'(cout), 64'd0);
    check("povf_zero", 64'(zero), 64'd0);

    run_one(64'd5, 64'd7, 1'b1, 1'b1, lat);
    check("sub5m7_S", S, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub5m7_cout", 64'(cout), 64'd0);
    check("sub5m7_ovf", 64'(ovf), 64'd0);

    run_one(64'd7, 64'd5, 1'b1, 1'b1, lat);
    check("sub7m5_S", S, 64'd2);
    check("sub7m5_cout", 64'(cout), 64'd1);

    run_one(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, lat);
    check("subovf_S", S, 64'h7FFF_FFFF_FFFF_FFFF);
    check("subovf_ovf", 64'(ovf), 64'd1);
    check("subovf_cout", 64'(cout), 64'd1);

    run_one(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, lat);
    check("cin_seg_S", S, 64'h0000_0000_0001_0000);
    check("cin_seg_zero", 64'(zero), 64'd0);

    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Back-to-back stream of 8 beats
    for (int t = 0; t < 16; t++) begin
      in_valid = (t < 8);
      A = 64'(t);
      B = 64'(t) << 16;
      cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      tick();
      check($sformatf("stream_valid_%0d", t), 64'(out_valid), 64'((t >= 3) && (t <= 10)));
      if ((t >= 3) && (t <= 10))
        check($sformatf("stream_S_%0d", t - 3), S, 64'(t - 3) + (64'(t - 3) << 16));
    end
    in_valid = 1'b0;

    // Backpressure for 3 cycles with results pending
    src = 0; got = 0; steps = 0;
    held_s = '0; held_f = '0;
    while ((src < 6 || q.size() > 0) && steps < 40) begin
      in_valid  = (src < 6);
      A         = 64'h1111 * 64'(src + 1);
      B         = (64'(src) << 48) | 64'hFFFF;
      out_ready = !(steps >= 4 && steps <= 6);
      #1;
      if (steps >= 4 && steps <= 6) begin
        check($sformatf("stall_in_ready_%0d", steps), 64'(in_ready), 64'd0);
        if (steps == 4) begin
          check("stall_out_valid", 64'(out_valid), 64'd1);
          held_s = S;
          held_f = {cout, ovf, zero};
        end else begin
          check($sformatf("stall_S_hold_%0d", steps), S, held_s);
          check($sformatf("stall_flag_hold_%0d", steps), 64'({cout, ovf, zero}), 64'(held_f));
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stall_extra_beat", 64'd1, 64'd0);
        else check($sformatf("stall_S_%0d", got), S, q.pop_front());
        got++;
      end
      in_fire = in_valid && in_ready;
      if (in_fire) begin
        q.push_back(A + B);
        src++;
      end
      @(posedge clk);
      #1;
      steps++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_count", 64'(got), 64'd6);
    check("stall_drain", 64'(q.size()), 64'd0);
    tick();

    // Reset with beats in flight
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      A = 64'(j + 1);
      B = 64'd0;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_S", S, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    stale = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      stale = stale | out_valid;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    run_one(64'd3, 64'd4, 1'b0, 1'b0, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_S", S, 64'd7);
    tick();

    // WIDTH=32, SEG=8
    run_32(32'h00FF_00FF, 32'h0001_0001, lat);
    check("w32_latency", 64'(lat), 64'd4);
    check("w32_S", 64'(s32), 64'h0100_0100);
    run_32(32'hFFFF_FFFF, 32'd1, lat);
    check("w32_wrap_S", 64'(s32), 64'd0);
    check("w32_wrap_flags", 64'({co32, of32, z32}), 64'b101);
    tick();

    // WIDTH=16, SEG=16
    run_16(16'h1234, 16'h4321, lat);
    check("w16_latency", 64'(lat), 64'd1);
    check("w16_S", 64'(s16), 64'h5555);
    run_16(16'h7FFF, 16'd1, lat);
    check("w16_ovf_S", 64'(s16), 64'h8000);
    check("w16_ovf_flags", 64'({co16, of16, z16}), 64'b010);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
